// File: rtl/gon_ctrl.sv
// gon_ctrl: sequencer for the two-level GON gather network.
// CONFIG loads the YID chain (NUM_ROW beats) and then the XID chain (NUM_ROW*NUM_COL beats)
// from a valid/ready ID source. RUN walks the (tag_Y, tag_X) grid one GON->GLB beat per pair.
// Optional per-tag watchdog enabled by defining GON_CTRL_TIMEOUT_EN.
module gon_ctrl #(
    parameter int unsigned NUM_ROW        = 6,
    parameter int unsigned NUM_COL        = 5,
    parameter int unsigned XID_BITS       = 5,
    parameter int unsigned YID_BITS       = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_cfg,
    input  logic                start_run,
    input  logic [YID_BITS-1:0] run_num_y,
    input  logic [XID_BITS-1:0] run_num_x,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [XID_BITS-1:0] cfg_id,
    output logic                set_YID,
    output logic [YID_BITS-1:0] YID_scan_in,
    output logic                set_XID,
    output logic [XID_BITS-1:0] XID_scan_in,
    output logic [YID_BITS-1:0] tag_Y,
    output logic [XID_BITS-1:0] tag_X,
    input  logic                mon_valid,
    input  logic                mon_ready,
    output logic                busy,
    output logic                cfg_done,
    output logic                run_done,
    output logic                timeout_err
);

    localparam int unsigned NUM_XID = NUM_ROW * NUM_COL;
    localparam int unsigned CNT_W   = $clog2(NUM_XID + 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD_Y = 3'd1;
    localparam logic [2:0] LOAD_X = 3'd2;
    localparam logic [2:0] RUN    = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    localparam logic [XID_BITS-1:0] X_ONE = 1;
    localparam logic [YID_BITS-1:0] Y_ONE = 1;

    // The watchdog limit must be nonzero for the per-tag counter to make sense.
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be nonzero");
    end

    logic [2:0]          state_q;
    logic [CNT_W-1:0]    beat_cnt_q;
    logic [YID_BITS-1:0] num_y_q;
    logic [XID_BITS-1:0] num_x_q;
    logic                accept;
    logic                last_x;
    logic                last_y;
    logic                advance;
    logic                tmo_hit;
    logic                run_accept;

    assign cfg_ready  = (state_q == LOAD_Y) || (state_q == LOAD_X);
    assign busy       = (state_q != IDLE);
    assign run_done   = (state_q == DONE);
    assign accept     = cfg_valid & cfg_ready;
    assign last_x     = (tag_X == num_x_q - X_ONE);
    assign last_y     = (tag_Y == num_y_q - Y_ONE);
    assign run_accept = (state_q == IDLE) & start_run & ~start_cfg;
    // A watchdog expiry advances the walk exactly like a completed beat.
    assign advance    = (mon_valid & mon_ready) | tmo_hit;

`ifdef GON_CTRL_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt_q;

    assign tmo_hit = (state_q == RUN) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

    // Per-tag wait counter and sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q   <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state_q != RUN || advance) begin
                tmo_cnt_q <= '0;
            end else begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
            if (run_accept) begin
                timeout_err <= 1'b0;
            end else if (tmo_hit && !(mon_valid && mon_ready)) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Main sequencer: state, beat counter, chain drive and tag walk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            num_y_q     <= '0;
            num_x_q     <= '0;
            set_YID     <= 1'b0;
            YID_scan_in <= '0;
            set_XID     <= 1'b0;
            XID_scan_in <= '0;
            tag_Y       <= '0;
            tag_X       <= '0;
            cfg_done    <= 1'b0;
        end else begin
            set_YID  <= 1'b0;
            set_XID  <= 1'b0;
            cfg_done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_cfg) begin
                        state_q    <= LOAD_Y;
                        beat_cnt_q <= '0;
                    end else if (start_run) begin
                        state_q <= RUN;
                        num_y_q <= run_num_y;
                        num_x_q <= run_num_x;
                        tag_Y   <= '0;
                        tag_X   <= '0;
                    end
                end
                LOAD_Y: begin
                    if (accept) begin
                        set_YID     <= 1'b1;
                        YID_scan_in <= cfg_id[YID_BITS-1:0];
                        if (beat_cnt_q == CNT_W'(NUM_ROW - 1)) begin
                            state_q    <= LOAD_X;
                            beat_cnt_q <= '0;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
                    end
                end
                LOAD_X: begin
                    if (accept) begin
                        set_XID     <= 1'b1;
                        XID_scan_in <= cfg_id;
                        if (beat_cnt_q == CNT_W'(NUM_XID - 1)) begin
                            state_q    <= IDLE;
                            beat_cnt_q <= '0;
                            cfg_done   <= 1'b1;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (num_y_q == '0 || num_x_q == '0) begin
                        state_q <= DONE;
                    end else if (advance) begin
                        if (last_x) begin
                            if (last_y) begin
                                // Final pair: tags stay on it through DONE/IDLE.
                                state_q <= DONE;
                            end else begin
                                tag_X <= '0;
                                tag_Y <= tag_Y + Y_ONE;
                            end
                        end else begin
                            tag_X <= tag_X + X_ONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gon_ctrl.sv
// tb_gon_ctrl: self-checking bench for gon_ctrl (table-driven run walk plus directed sequences).
module tb_gon_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_cfg, start_run;
    logic [2:0] run_num_y;
    logic [4:0] run_num_x;
    logic       cfg_valid, cfg_ready;
    logic [4:0] cfg_id;
    logic       set_YID, set_XID;
    logic [2:0] YID_scan_in;
    logic [4:0] XID_scan_in;
    logic [2:0] tag_Y;
    logic [4:0] tag_X;
    logic       mon_valid, mon_ready;
    logic       busy, cfg_done, run_done, timeout_err;

    always #5 clk = ~clk;

    gon_ctrl #(
        .NUM_ROW(6), .NUM_COL(5), .XID_BITS(5), .YID_BITS(3), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst), .start_cfg(start_cfg), .start_run(start_run),
        .run_num_y(run_num_y), .run_num_x(run_num_x), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .cfg_id(cfg_id), .set_YID(set_YID), .YID_scan_in(YID_scan_in),
        .set_XID(set_XID), .XID_scan_in(XID_scan_in), .tag_Y(tag_Y), .tag_X(tag_X),
        .mon_valid(mon_valid), .mon_ready(mon_ready), .busy(busy), .cfg_done(cfg_done),
        .run_done(run_done), .timeout_err(timeout_err)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One row per cycle: inputs driven for the coming edge, outputs expected at this negedge.
    typedef struct {
        logic       sr;
        logic       mv;
        logic       mr;
        logic       busy;
        logic [2:0] y;
        logic [4:0] x;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic sr, input logic mv, input logic mr, input logic b,
                           input int y, input int x, input logic d);
        vec_t v;
        v.sr = sr; v.mv = mv; v.mr = mr; v.busy = b;
        v.y = 3'(y); v.x = 5'(x); v.done = d;
        vecs.push_back(v);
    endtask

    // Config-load monitor.
    logic       mon_en = 1'b0;
    logic [2:0] yq[$];
    logic [4:0] xq[$];
    int         done_cnt = 0;
    int         done_xlen = -1;
    logic       done_with_set = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (set_YID) yq.push_back(YID_scan_in);
            if (set_XID) xq.push_back(XID_scan_in);
            if (cfg_done) begin
                done_cnt++;
                done_xlen = xq.size();
                done_with_set = set_XID;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the beat is accepted.
    task automatic send_beat(input int id);
        int n = 0;
        cfg_valid = 1'b1;
        cfg_id    = 5'(id);
        while (!cfg_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            errors++;
            checks++;
            $display("FAIL beat_wait: id %0d never accepted, got ready=%0d expected 1", id, cfg_ready);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start_cfg = 0; start_run = 0; run_num_y = 0; run_num_x = 0;
        cfg_valid = 0; cfg_id = 0; mon_valid = 0; mon_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_cfg_ready", cfg_ready, 0);
        chk("rst_set_yid", set_YID, 0);
        chk("rst_set_xid", set_XID, 0);
        chk("rst_tags", {tag_Y, tag_X}, 0);
        chk("rst_dones", {cfg_done, run_done}, 0);
        chk("rst_timeout", timeout_err, 0);
        rst = 1'b0;

        // Walk 2x3 free-flowing, then again with a 5-cycle stall at (0,1).
        add_vec(1, 1, 1, 0, 0, 0, 0);
        add_vec(0, 1, 1, 1, 0, 0, 0);
        add_vec(0, 1, 1, 1, 0, 1, 0);
        add_vec(0, 1, 1, 1, 0, 2, 0);
        add_vec(0, 1, 1, 1, 1, 0, 0);
        add_vec(0, 1, 1, 1, 1, 1, 0);
        add_vec(0, 1, 1, 1, 1, 2, 0);
        add_vec(0, 1, 1, 1, 1, 2, 1);
        add_vec(1, 1, 1, 0, 1, 2, 0);
        add_vec(0, 1, 1, 1, 0, 0, 0);
        for (int k = 0; k < 5; k++) add_vec(0, 1, 0, 1, 0, 1, 0);
        add_vec(0, 1, 1, 1, 0, 1, 0);
        add_vec(0, 1, 1, 1, 0, 2, 0);
        add_vec(0, 1, 1, 1, 1, 0, 0);
        add_vec(0, 1, 1, 1, 1, 1, 0);
        add_vec(0, 1, 1, 1, 1, 2, 0);
        add_vec(0, 0, 0, 1, 1, 2, 1);
        add_vec(0, 0, 0, 0, 1, 2, 0);

        run_num_y = 3'd2;
        run_num_x = 5'd3;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
            chk($sformatf("vec%0d_tag_y", i), tag_Y, vecs[i].y);
            chk($sformatf("vec%0d_tag_x", i), tag_X, vecs[i].x);
            chk($sformatf("vec%0d_run_done", i), run_done, vecs[i].done);
            start_run = vecs[i].sr;
            mon_valid = vecs[i].mv;
            mon_ready = vecs[i].mr;
        end
        @(negedge clk);

        // Reset in the middle of the X load (7th X beat).
        start_cfg = 1'b1;
        @(negedge clk);
        start_cfg = 1'b0;
        for (int i = 0; i < 13; i++) send_beat(i);
        chk("midload_set_xid_before", set_XID, 1);
        rst = 1'b1;
        #1;
        chk("midload_busy", busy, 0);
        chk("midload_cfg_ready", cfg_ready, 0);
        chk("midload_set_xid", set_XID, 0);
        @(negedge clk);
        rst = 1'b0;

        // Full load of IDs 0..35 with random valid gaps.
        yq.delete();
        xq.delete();
        mon_en = 1'b1;
        @(negedge clk);
        start_cfg = 1'b1;
        @(negedge clk);
        start_cfg = 1'b0;
        for (int i = 0; i < 36; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_beat(i);
        end
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        chk("load_y_count", yq.size(), 6);
        chk("load_x_count", xq.size(), 30);
        for (int i = 0; i < 6 && i < yq.size(); i++) chk($sformatf("load_y%0d", i), yq[i], i);
        for (int i = 0; i < 30 && i < xq.size(); i++)
            chk($sformatf("load_x%0d", i), xq[i], (i + 6) % 32);
        chk("cfg_done_count", done_cnt, 1);
        chk("cfg_done_on_last_x", done_xlen, 30);
        chk("cfg_done_with_set_xid", done_with_set, 1);
        chk("load_end_busy", busy, 0);
        chk("load_end_ready", cfg_ready, 0);

        // Zero counts: straight to DONE, no tags issued.
        run_num_y = 3'd3;
        run_num_x = 5'd0;
        start_run = 1'b1;
        @(negedge clk);
        start_run = 1'b0;
        chk("zx_c1_busy", busy, 1);
        chk("zx_c1_done", run_done, 0);
        @(negedge clk);
        chk("zx_c2_done", run_done, 1);
        chk("zx_c2_tags", {tag_Y, tag_X}, 0);
        @(negedge clk);
        chk("zx_c3_busy", busy, 0);
        run_num_y = 3'd0;
        run_num_x = 5'd4;
        start_run = 1'b1;
        @(negedge clk);
        start_run = 1'b0;
        @(negedge clk);
        chk("zy_c2_done", run_done, 1);
        chk("zy_c2_tags", {tag_Y, tag_X}, 0);
        @(negedge clk);

        // start_cfg and start_run together: config wins; start_run in LOAD_Y is ignored.
        run_num_y = 3'd2;
        run_num_x = 5'd3;
        start_cfg = 1'b1;
        start_run = 1'b1;
        @(negedge clk);
        start_cfg = 1'b0;
        start_run = 1'b0;
        chk("both_cfg_ready", cfg_ready, 1);
        chk("both_run_done", run_done, 0);
        start_run = 1'b1;
        @(negedge clk);
        start_run = 1'b0;
        chk("run_in_load_ready", cfg_ready, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Stalled tag: watchdog advance when enabled, indefinite wait otherwise.
        run_num_y = 3'd1;
        run_num_x = 5'd2;
        mon_valid = 1'b0;
        mon_ready = 1'b0;
        start_run = 1'b1;
        @(negedge clk);
        start_run = 1'b0;
`ifdef GON_CTRL_TIMEOUT_EN
        repeat (15) @(negedge clk);
        chk("tmo_c16_tag_x", tag_X, 0);
        chk("tmo_c16_err", timeout_err, 0);
        @(negedge clk);
        chk("tmo_c17_tag_x", tag_X, 1);
        chk("tmo_c17_err", timeout_err, 1);
        repeat (15) @(negedge clk);
        chk("tmo_c32_tag_x", tag_X, 1);
        chk("tmo_c32_done", run_done, 0);
        @(negedge clk);
        chk("tmo_c33_done", run_done, 1);
        @(negedge clk);
        chk("tmo_sticky", timeout_err, 1);
        mon_valid = 1'b1;
        mon_ready = 1'b1;
        start_run = 1'b1;
        @(negedge clk);
        start_run = 1'b0;
        chk("tmo_cleared", timeout_err, 0);
        repeat (4) @(negedge clk);
`else
        repeat (40) @(negedge clk);
        chk("stall_tag_x", tag_X, 0);
        chk("stall_busy", busy, 1);
        chk("stall_err", timeout_err, 0);
        mon_valid = 1'b1;
        mon_ready = 1'b1;
        @(negedge clk);
        chk("stall_resume_tag_x", tag_X, 1);
        @(negedge clk);
        chk("stall_resume_done", run_done, 1);
        @(negedge clk);
`endif
        mon_valid = 1'b0;
        mon_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
